// File: rtl/spi_master_pkg.sv
// Shared encodings for the SPI master.
// FSM states and SPI mode codes ({cpol,cpha}).
package spi_master_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_master_mc_clkgen.sv
// SCK generator: divider counter, half-period tick,
// leading/trailing edge strobes and the SCK register.
module spi_clkgen
  import spi_master_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             shift,
  input  logic [DIV_W-1:0] div,
  input  logic             pol,
  output logic             tick,
  output logic             lead,
  output logic             trail,
  output logic             sck
);

  logic [DIV_W-1:0] cnt;
  logic             phase;

  assign tick  = !clr && (cnt == '0);
  assign lead  = tick && shift && !phase;
  assign trail = tick && shift && phase;

  // half-period counter, reloaded at every boundary
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      cnt <= div;
    end else if (tick) begin
      cnt <= div;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  // SCK toggles on each shift half-period boundary
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      phase <= 1'b0;
      sck   <= pol;
    end else if (lead || trail) begin
      phase <= ~phase;
      sck   <= ~sck;
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// SPI master: frame FSM, shifter, bit counter,
// chip-select decode and RX holding register.
module spi_master_mc
  import spi_master_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CS   = 4,
  parameter int DIV_W  = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cfg_cpol,
  input  logic                          cfg_cpha,
  input  logic                          cfg_lsb,
  input  logic [$clog2(DATA_W+1)-1:0]   cfg_len,
  input  logic [DIV_W-1:0]              cfg_div,
  // one spare code point so "no slave" is representable
  input  logic [$clog2(N_CS+1)-1:0]     cfg_cs_sel,
  input  logic                          cfg_hold_cs,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_W-1:0]             tx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_overrun,
  output logic                          busy,
  output logic                          spi_sck,
  output logic [N_CS-1:0]               spi_csb,
  output logic                          spi_mosi,
  output logic                          spi_sdoenb,
  input  logic                          spi_miso
);

  localparam int LW = $clog2(DATA_W+1);
  localparam int CW = $clog2(N_CS+1);
  localparam logic [LW-1:0] LMAX = LW'(DATA_W);

  logic [1:0]        state;
  logic              cpol_q, cpha_q, lsb_q;
  logic [LW-1:0]     len_q, tcnt, len_eff, lm1;
  logic [DIV_W-1:0]  div_q, div_sel;
  logic [CW-1:0]     cs_q;
  logic [DATA_W-1:0] sh, shr, shl, tx_m, lmask;
  logic              fin, mosi_q, rdy_q;
  logic              accept, cap, clr, pol_sel;
  logic              tick, lead, trail, drive_e, samp_e, top;
  logic [N_CS-1:0]   csb_q, csb_n;
  logic              sdoenb_q;

  function automatic logic pick(
    input logic [DATA_W-1:0] v,
    input logic [LW-1:0]     k
  );
    pick = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (LW'(i) == k) pick = v[i];
    end
  endfunction

  assign accept   = tx_valid && tx_ready;
  assign cap      = (state == ST_SHIFT) && fin;
  assign clr      = (state == ST_IDLE) || fin;
  assign lm1      = len_q - 1'b1;
  assign len_eff  = (cfg_len == '0 || cfg_len > LMAX)
                  ? LMAX : cfg_len;
  assign div_sel  = (state == ST_IDLE) ? cfg_div : div_q;
  assign pol_sel  = (state == ST_IDLE || !resetn)
                  ? cfg_cpol : cpol_q;
  assign drive_e  = cpha_q ? lead : trail;
  assign samp_e   = cpha_q ? trail : lead;
  assign top      = lsb_q ? sh[0] : pick(sh, lm1);
  assign shl      = (sh << 1) | DATA_W'(spi_miso);

  assign tx_ready   = rdy_q;
  assign busy       = (state != ST_IDLE);
  assign spi_mosi   = mosi_q;
  assign spi_csb    = csb_q;
  assign spi_sdoenb = sdoenb_q;

  // length masks for load and output, right shift with MISO at len-1
  always_comb begin
    shr = sh >> 1;
    for (int i = 0; i < DATA_W; i++) begin
      tx_m[i]  = tx_data[i] && (i < int'(len_eff));
      lmask[i] = (i < int'(len_q));
      if (LW'(i) == lm1) shr[i] = spi_miso;
    end
  end

  spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr),
    .shift  ((state == ST_SHIFT) && !fin),
    .div    (div_sel),
    .pol    (pol_sel),
    .tick   (tick),
    .lead   (lead),
    .trail  (trail),
    .sck    (spi_sck)
  );

  // frame FSM, config latch, shifter and bit counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      fin    <= 1'b0;
      tcnt   <= '0;
      sh     <= '0;
      mosi_q <= 1'b0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q  <= 1'b0;
      len_q  <= LMAX;
      div_q  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_SETUP;
            cpol_q <= cfg_cpol;
            cpha_q <= cfg_cpha;
            lsb_q  <= cfg_lsb;
            len_q  <= len_eff;
            div_q  <= cfg_div;
            sh     <= tx_m;
            tcnt   <= '0;
            fin    <= 1'b0;
            mosi_q <= cfg_lsb ? tx_data[0]
                    : pick(tx_data, len_eff - 1'b1);
          end
        end
        ST_SETUP: begin
          if (tick) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (fin) begin
            fin   <= 1'b0;
            state <= ST_HOLD;
          end else begin
            if (samp_e) sh <= lsb_q ? shr : shl;
            if (drive_e) mosi_q <= top;
            if (trail) begin
              tcnt <= tcnt + 1'b1;
              if (tcnt == lm1) fin <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (tick) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // tx_ready: low in reset cycle and from accept until HOLD ends
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdy_q <= 1'b0;
    end else if (accept) begin
      rdy_q <= 1'b0;
    end else if (state == ST_IDLE ||
                 (state == ST_HOLD && tick)) begin
      rdy_q <= 1'b1;
    end
  end

  // RX holding register; a completing frame beats rx_ready
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_overrun <= 1'b0;
    end else if (cap) begin
      rx_data  <= sh & lmask;
      rx_valid <= 1'b1;
      if (rx_valid && !rx_ready) rx_overrun <= 1'b1;
    end else if (rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // next chip-select pattern: assert on accept, release in IDLE
  always_comb begin
    csb_n = csb_q;
    if (state == ST_IDLE) begin
      if (accept) begin
        for (int i = 0; i < N_CS; i++) begin
          csb_n[i] = !(CW'(i) == cfg_cs_sel);
        end
      end else if (!cfg_hold_cs || cfg_cs_sel != cs_q) begin
        csb_n = '1;
      end
    end
  end

  // chip-select and MOSI pad-enable registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      csb_q    <= '1;
      sdoenb_q <= 1'b1;
      cs_q     <= '1;
    end else begin
      csb_q    <= csb_n;
      sdoenb_q <= &csb_n;
      if (accept) cs_q <= cfg_cs_sel;
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// Scoreboard bench for spi_master_mc: loopback and
// a mode-3 flash-like slave, plus CS/reset corner cases.
module tb_spi_master_mc;
  import spi_master_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       cfg_cpol, cfg_cpha, cfg_lsb, cfg_hold_cs;
  logic [3:0] cfg_len;
  logic [7:0] cfg_div;
  logic [2:0] cfg_cs_sel;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid, rx_ready, rx_overrun, busy;
  logic [7:0] rx_data;
  logic       spi_sck, spi_mosi, spi_sdoenb, spi_miso;
  logic [3:0] spi_csb;

  logic       loop;
  logic       slv_miso;
  logic [6:0] sb;
  logic [31:0] srx;
  logic [63:0] resp;
  logic [7:0] exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic       watch;
  int         viol;
  logic       mon_en;
  int         midx;
  logic [4:0] seq;
  time        tsck[2];

  always #5 clk = ~clk;

  assign spi_miso = loop ? spi_mosi : slv_miso;

  spi_master_mc #(.DATA_W(8), .N_CS(4), .DIV_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb(cfg_lsb), .cfg_len(cfg_len),
    .cfg_div(cfg_div), .cfg_cs_sel(cfg_cs_sel),
    .cfg_hold_cs(cfg_hold_cs),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_overrun(rx_overrun),
    .busy(busy), .spi_sck(spi_sck), .spi_csb(spi_csb),
    .spi_mosi(spi_mosi), .spi_sdoenb(spi_sdoenb),
    .spi_miso(spi_miso)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  // scoreboard monitor: every RX handshake pops one expectation
  always @(negedge clk) begin
    if (resetn === 1'b1 && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        check("rx_unexpected", {24'h0, rx_data}, 32'hdead);
      end else begin
        check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // CS continuity watcher
  always @(negedge clk) begin
    if (watch && (spi_csb !== 4'b1011 || spi_sdoenb !== 1'b0))
      viol++;
  end

  // MOSI/SCK recorder on mode-0 leading edges
  always @(posedge spi_sck) begin
    if (mon_en && midx < 5) begin
      seq[midx] = spi_mosi;
      if (midx < 2) tsck[midx] = $time;
      midx++;
    end
  end

  // mode-3 slave: capture MOSI on rising SCK
  always @(posedge spi_sck or posedge spi_csb[0]) begin
    if (spi_csb[0]) begin
      sb  <= '0;
      srx <= '0;
    end else begin
      if (sb < 7'd32) srx <= {srx[30:0], spi_mosi};
      if (sb < 7'd64) sb <= sb + 7'd1;
    end
  end

  // mode-3 slave: drive MISO on falling SCK
  always @(negedge spi_sck) begin
    logic [5:0] idx;
    if (!spi_csb[0]) begin
      idx = 6'(7'd63 - sb);
      slv_miso = resp[idx];
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!tx_ready && n < 2000) begin
      cyc(1);
      n++;
    end
    if (!tx_ready) check(nm, 32'h0, 32'h1);
  endtask

  task automatic send(input logic [7:0] d,
                      input logic [1:0] mode,
                      input logic lsb,
                      input logic [3:0] len,
                      input logic [7:0] div,
                      input logic [2:0] cs,
                      input logic hold);
    {cfg_cpol, cfg_cpha} = mode;
    cfg_lsb     = lsb;
    cfg_len     = len;
    cfg_div     = div;
    cfg_cs_sel  = cs;
    cfg_hold_cs = hold;
    tx_data     = d;
    cyc(1);
    wait_ready("accept_timeout");
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    resetn = 1'b0;
    {cfg_cpol, cfg_cpha} = MODE0;
    cfg_lsb = 0; cfg_len = 8; cfg_div = 0;
    cfg_cs_sel = 0; cfg_hold_cs = 0;
    tx_valid = 0; tx_data = 0; rx_ready = 1;
    loop = 1; slv_miso = 0; watch = 0; viol = 0;
    mon_en = 0; midx = 0; seq = '0;
    resp = 64'h0000_0000_9301_0013;
    cyc(3);
    check("rst_tx_ready", {31'h0, tx_ready}, 32'h0);
    check("rst_csb", {28'h0, spi_csb}, 32'hf);
    check("rst_sck", {31'h0, spi_sck}, 32'h0);
    check("rst_mosi", {31'h0, spi_mosi}, 32'h0);
    check("rst_sdoenb", {31'h0, spi_sdoenb}, 32'h1);
    check("rst_rx", {22'h0, rx_valid, rx_overrun, rx_data},
          32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    resetn = 1'b1;
    cyc(1);
    check("tx_ready_after_rst", {31'h0, tx_ready}, 32'h1);

    // mode 0 loopback, latency
    exp_q.push_back(8'hA5);
    send(8'hA5, MODE0, 0, 8, 0, 0, 0);
    n = 0;
    while (!rx_valid && n < 100) begin cyc(1); n++; end
    check("rx_latency", n, 18);
    while (!tx_ready && n < 100) begin cyc(1); n++; end
    check("tx_ready_latency", n, 19);
    cyc(2);

    // LSB-first, len 5, div 1
    mon_en = 1; midx = 0;
    exp_q.push_back(8'h13);
    send(8'h13, MODE0, 1, 5, 1, 1, 0);
    wait_ready("lsb_timeout");
    mon_en = 0;
    check("lsb_mosi_seq", {27'h0, seq}, 32'h13);
    check("sck_period", 32'(tsck[1] - tsck[0]), 40);
    cyc(2);

    // held CS across three frames on slave 2
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    send(8'h11, MODE0, 0, 8, 0, 2, 1);
    watch = 1;
    send(8'h22, MODE0, 0, 8, 0, 2, 1);
    send(8'h33, MODE0, 0, 8, 0, 2, 1);
    wait_ready("hold_timeout");
    cyc(3);
    watch = 0;
    check("hold_cs_glitches", viol, 0);
    check("hold_cs_idle", {28'h0, spi_csb}, 32'hb);
    cfg_hold_cs = 0;
    cyc(1);
    check("hold_release", {27'h0, spi_sdoenb, spi_csb}, 32'h1f);
    cyc(2);

    // mode 3 read of a flash-like slave
    loop = 0;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h93); exp_q.push_back(8'h01);
    exp_q.push_back(8'h00); exp_q.push_back(8'h13);
    send(8'h03, MODE3, 0, 8, 3, 0, 1);
    for (int i = 0; i < 7; i++) send(8'h00, MODE3, 0, 8, 3, 0, 1);
    wait_ready("mode3_timeout");
    cyc(2);
    check("slave_cmd_addr", srx, 32'h0300_0000);
    cfg_hold_cs = 0;
    cyc(2);
    loop = 1;

    // overrun with invalid CS select
    rx_ready = 0;
    send(8'h5A, MODE0, 0, 8, 0, 5, 0);
    cyc(5);
    check("cs5_csb", {27'h0, spi_sdoenb, spi_csb}, 32'h1f);
    wait_ready("ovr1_timeout");
    check("ovr_first", {30'h0, rx_valid, rx_overrun}, 32'h2);
    send(8'h3C, MODE0, 0, 8, 0, 5, 0);
    wait_ready("ovr2_timeout");
    check("ovr_set", {31'h0, rx_overrun}, 32'h1);
    exp_q.push_back(8'h3C);
    rx_ready = 1;
    cyc(2);
    check("ovr_drained", {31'h0, rx_valid}, 32'h0);

    // reset in the middle of SHIFT
    send(8'h77, MODE2, 0, 8, 3, 1, 0);
    cyc(12);
    check("mid_busy", {31'h0, busy}, 32'h1);
    resetn = 1'b0;
    cyc(1);
    check("midrst_csb", {28'h0, spi_csb}, 32'hf);
    check("midrst_sck", {31'h0, spi_sck}, 32'h1);
    check("midrst_flags",
          {28'h0, rx_valid, rx_overrun, busy, tx_ready}, 32'h0);
    resetn = 1'b1;
    cyc(60);
    check("midrst_no_rx", {31'h0, rx_valid}, 32'h0);
    check("midrst_ready", {31'h0, tx_ready}, 32'h1);
    check("scoreboard_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
